// File: rtl/leaf_packetizer.sv
// Leaf packetizer: wraps user words into BFT packets with a sequence address,
// enforces credit-based flow control and can re-drive the last packet on request.
module leaf_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk_bft,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic                     credit_vld,
  input  logic                     resend,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  output logic [NUM_ADDR_BITS:0]   credit_cnt,
  output logic [15:0]              pkt_count
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int unsigned MAX_CREDIT = 1 << NUM_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, SEND, RESEND} state_e;

  state_e                   state_q;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic [CW-1:0]            credit_q, credit_d;
  logic [15:0]              pkt_count_q;
  logic                     has_sent_q;
  logic [PACKET_BITS-1:0]   last_pkt_q, pkt_d;
  logic [31:0]              credit_sum;
  logic                     xfer;

  // Ack depends only on flops, reset and resend -- never on the user's valid.
  assign ack_interface2user = reset & (credit_q != '0) & ~resend;
  assign xfer               = vld_user2interface & ack_interface2user;

  // Header fields are packed MSB-first above the payload.
  assign pkt_d = PACKET_BITS'({1'b1, dest_leaf, dest_port, addr_q, din_leaf_user2interface});

  // Credit next-state: add the freespace update, subtract one per transfer,
  // saturate at the full window. A transfer implies credit_q >= 1, so no underflow.
  always_comb begin
    credit_sum = {{(32-CW){1'b0}}, credit_q};
    if (credit_vld) credit_sum = credit_sum + 32'(FREESPACE_UPDATE_SIZE);
    if (xfer)       credit_sum = credit_sum - 32'd1;
    credit_d = (credit_sum > 32'(MAX_CREDIT)) ? CW'(MAX_CREDIT) : credit_sum[CW-1:0];
  end

  // State machine plus all datapath registers; resend freezes addr/count/credit
  // (credit_vld still lands, since it reports receiver space, not our sends).
  always_ff @(posedge clk_bft) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      credit_q    <= CW'(MAX_CREDIT);
      pkt_count_q <= '0;
      has_sent_q  <= 1'b0;
      last_pkt_q  <= '0;
    end else begin
      credit_q <= credit_d;
      if (resend) begin
        state_q <= RESEND;
      end else if (xfer) begin
        state_q     <= SEND;
        last_pkt_q  <= pkt_d;
        has_sent_q  <= 1'b1;
        addr_q      <= addr_q + 1'b1;
        pkt_count_q <= pkt_count_q + 16'd1;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  // Output is a pure mux of flops: in SEND last_pkt is the packet just
  // captured; in RESEND it is replayed only if something was ever sent.
  assign dout_leaf_interface2bft =
    ((state_q == SEND) || (state_q == RESEND && has_sent_q)) ? last_pkt_q : '0;

  assign credit_cnt = credit_q;
  assign pkt_count  = pkt_count_q;

endmodule
